cofi_multi: RTL and testbench



---
 rtl/cofi_multi_pkg.sv | 26 ++
 rtl/cofi_multi_chan.sv | 53 +++++
 rtl/cofi_multi.sv | 111 +++++++++++
 tb/tb_cofi_multi.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cofi_multi_pkg.sv
// Shared types and helpers for the cofi_multi horizontal blur.
// Kernel selection, line-tracking states, rounding offsets and channel slicing.
package cofi_multi_pkg;

   typedef enum logic [1:0] {
      COFI_2TAP_HALF = 2'd0,
      COFI_2TAP_3Q   = 2'd1,
      COFI_3TAP      = 2'd2,
      COFI_RSVD      = 2'd3
   } cofi_mode_e;

   typedef enum logic {
      LINE_IDLE   = 1'b0,
      LINE_ACTIVE = 1'b1
   } line_state_e;

   // Round-half-up offsets for the >>1 and >>2 kernels
   localparam int unsigned RND_HALF    = 1;
   localparam int unsigned RND_QUARTER = 2;

   // LSB position of channel ch in a packed pixel, channel 0 in the LSBs
   function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned dw);
      return ch * dw;
   endfunction

endpackage

// File: rtl/cofi_multi_chan.sv
// Single-channel blur kernel: blends prev/cur/next according to the selected mode.
// Purely combinational; the intermediate is two bits wider so no term can overflow.
module cofi_multi_chan
   import cofi_multi_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] prev_i,
   input  logic [DW-1:0] cur_i,
   input  logic [DW-1:0] next_i,
   input  cofi_mode_e    mode_i,
   output logic [DW-1:0] kern_c_o
);

   localparam int unsigned IW = DW + 2;

   logic [IW-1:0] prev_w;
   logic [IW-1:0] cur_w;
   logic [IW-1:0] next_w;
   logic [IW-1:0] sum_c;
   logic          quarter_c;

   assign prev_w = IW'(prev_i);
   assign cur_w  = IW'(cur_i);
   assign next_w = IW'(next_i);

   // Weighted sum and divisor select; every result is at most 4*(2^DW-1)+2
   always_comb begin
      sum_c     = prev_w + cur_w + IW'(RND_HALF);
      quarter_c = 1'b0;
      case (mode_i)
         COFI_2TAP_3Q: begin
            sum_c     = (cur_w << 1) + cur_w + prev_w + IW'(RND_QUARTER);
            quarter_c = 1'b1;
         end
         COFI_3TAP: begin
            sum_c     = prev_w + (cur_w << 1) + next_w + IW'(RND_QUARTER);
            quarter_c = 1'b1;
         end
         COFI_2TAP_HALF, COFI_RSVD: begin
            sum_c     = prev_w + cur_w + IW'(RND_HALF);
            quarter_c = 1'b0;
         end
         default: begin
            sum_c     = prev_w + cur_w + IW'(RND_HALF);
            quarter_c = 1'b0;
         end
      endcase
   end

   assign kern_c_o = quarter_c ? DW'(sum_c >> 2) : DW'(sum_c >> 1);

endmodule

// File: rtl/cofi_multi.sv
// Composite-style horizontal blur: 3-pixel window, edge replication, selectable kernel.
// Two pix_ce of latency in every mode; mode/enable only change between lines.
module cofi_multi
   import cofi_multi_pkg::*;
#(
   parameter int unsigned DW = 8,
   parameter int unsigned CH = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            pix_ce,
   input  logic            enable,
   input  logic [1:0]      mode,
   input  logic            blank,
   input  logic [CH*DW-1:0] pix_in,
   output logic [CH*DW-1:0] pix_out,
   output logic            blank_out
);

   localparam int unsigned PW = CH * DW;

   logic [PW-1:0] p0_q, p1_q, p2_q;
   logic          b0_q, b1_q, b2_q;
   cofi_mode_e    mode_q;
   logic          enable_q;
   line_state_e   state_q, state_d;
   logic          latch_c;

   logic [PW-1:0] prev_c;
   logic [PW-1:0] next_c;
   logic [PW-1:0] kern_c;
   logic [PW-1:0] pix_d;

   // Blank neighbours are replaced by the centre pixel at both line edges
   assign prev_c = b2_q ? p1_q : p2_q;
   assign next_c = b0_q ? p1_q : p0_q;

   for (genvar g = 0; g < CH; g++) begin : g_chan
      localparam int unsigned LSB = chan_lsb(g, DW);
      cofi_multi_chan #(
         .DW (DW)
      ) u_chan (
         .prev_i   (prev_c[LSB +: DW]),
         .cur_i    (p1_q[LSB +: DW]),
         .next_i   (next_c[LSB +: DW]),
         .mode_i   (mode_q),
         .kern_c_o (kern_c[LSB +: DW])
      );
   end

   assign pix_d = (enable_q && !b1_q) ? kern_c : p1_q;

   // Line tracker on the centre blank bit; settings load only while idle in blanking
   always_comb begin
      state_d = state_q;
      latch_c = 1'b0;
      case (state_q)
         LINE_IDLE: begin
            latch_c = b1_q;
            if (!b1_q) begin
               state_d = LINE_ACTIVE;
            end
         end
         LINE_ACTIVE: begin
            if (b1_q) begin
               state_d = LINE_IDLE;
            end
         end
         default: begin
            state_d = LINE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= LINE_IDLE;
         mode_q   <= COFI_2TAP_HALF;
         enable_q <= 1'b0;
      end else if (pix_ce) begin
         state_q <= state_d;
         if (latch_c) begin
            mode_q   <= cofi_mode_e'(mode);
            enable_q <= enable;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p0_q      <= '0;
         p1_q      <= '0;
         p2_q      <= '0;
         b0_q      <= 1'b1;
         b1_q      <= 1'b1;
         b2_q      <= 1'b1;
         pix_out   <= '0;
         blank_out <= 1'b1;
      end else if (pix_ce) begin
         p2_q      <= p1_q;
         p1_q      <= p0_q;
         p0_q      <= pix_in;
         b2_q      <= b1_q;
         b1_q      <= b0_q;
         b0_q      <= blank;
         pix_out   <= pix_d;
         blank_out <= b1_q;
      end
   end

endmodule

// File: tb/tb_cofi_multi.sv
// Self-checking bench for cofi_multi: directed line table, reset corner, and
// randomized pix_ce-gated traffic against a behavioural window model.
module tb_cofi_multi;

   localparam int unsigned DW = 8;
   localparam int unsigned CH = 3;
   localparam int unsigned PW = DW * CH;
   localparam logic B = 1'b1;
   localparam logic A = 1'b0;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          pix_ce;
   logic          enable;
   logic [1:0]    mode;
   logic          blank;
   logic [PW-1:0] pix_in;
   logic [PW-1:0] pix_out;
   logic          blank_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cofi_multi #(.DW(DW), .CH(CH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pix_ce    (pix_ce),
      .enable    (enable),
      .mode      (mode),
      .blank     (blank),
      .pix_in    (pix_in),
      .pix_out   (pix_out),
      .blank_out (blank_out)
   );

   typedef struct {
      logic [1:0] mode;
      logic       en;
      logic       blank;
      logic [7:0] r;
      logic [7:0] exp_r;
      logic       exp_b;
   } vec_t;

   vec_t tbl[32];

   function automatic logic [PW-1:0] rep(input logic [7:0] v);
      return {CH{v}};
   endfunction

   task automatic check(input string name, input logic [PW-1:0] exp_p, input logic exp_b);
      n_vec++;
      if (pix_out !== exp_p || blank_out !== exp_b) begin
         n_err++;
         $display("FAIL %s: pix_out=%h blank_out=%b, required pix_out=%h blank_out=%b",
                  name, pix_out, blank_out, exp_p, exp_b);
      end
   endtask

   task automatic drive(input logic ce, input logic [1:0] m, input logic en,
                        input logic b, input logic [PW-1:0] p);
      @(negedge clk);
      pix_ce = ce;
      mode   = m;
      enable = en;
      blank  = b;
      pix_in = p;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      pix_ce  = 1'b0;
      blank   = 1'b1;
      reset_n = 1'b0;
      #1;
      check(name, '0, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Behavioural model: history of the last three accepted pixels, newest first
   logic [PW-1:0] hp[3];
   logic          hb[3];
   logic          m_en;
   logic [1:0]    m_mode;
   logic          m_prev_blank;
   logic [PW-1:0] m_out;
   logic          m_bout;

   function automatic int kern(input int m, input int pv, input int c, input int nx);
      case (m)
         1:       return (3 * c + pv + 2) / 4;
         2:       return (pv + 2 * c + nx + 2) / 4;
         default: return (pv + c + 1) / 2;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         hp[i] = '0;
         hb[i] = 1'b1;
      end
      m_en = 1'b0;
      m_mode = 2'd0;
      m_prev_blank = 1'b1;
      m_out = '0;
      m_bout = 1'b1;
   endtask

   task automatic model_step(input logic b, input logic [PW-1:0] p,
                             input logic [1:0] m, input logic en);
      if (m_en && !hb[1]) begin
         for (int ch = 0; ch < int'(CH); ch++) begin
            int c, pv, nx;
            c  = int'(hp[1][ch*DW +: DW]);
            pv = hb[2] ? c : int'(hp[2][ch*DW +: DW]);
            nx = hb[0] ? c : int'(hp[0][ch*DW +: DW]);
            m_out[ch*DW +: DW] = DW'(kern(int'(m_mode), pv, c, nx));
         end
      end else begin
         m_out = hp[1];
      end
      m_bout = hb[1];
      // Settings are taken when two consecutive centre pixels are blank
      if (hb[1] && m_prev_blank) begin
         m_en   = en;
         m_mode = m;
      end
      m_prev_blank = hb[1];
      hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = p;
      hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = b;
   endtask

   initial begin
      logic       rce, rb, ren;
      logic [1:0] rm;
      logic [PW-1:0] rp;

      reset_n = 1'b1;
      pix_ce  = 1'b0;
      enable  = 1'b0;
      mode    = 2'd0;
      blank   = 1'b1;
      pix_in  = '0;

      //            mode en blank  r     exp_r exp_b
      tbl[0]  = '{2'd0, 1, B, 8'h33, 8'h00, 1};
      tbl[1]  = '{2'd0, 1, B, 8'h33, 8'h00, 1};
      tbl[2]  = '{2'd0, 1, B, 8'h33, 8'h33, 1};
      tbl[3]  = '{2'd0, 1, A, 8'h00, 8'h33, 1};
      tbl[4]  = '{2'd0, 1, A, 8'hFF, 8'h33, 1};
      tbl[5]  = '{2'd0, 1, A, 8'h10, 8'h00, 0};
      tbl[6]  = '{2'd0, 1, B, 8'h33, 8'h80, 0};
      tbl[7]  = '{2'd0, 1, B, 8'h33, 8'h88, 0};
      tbl[8]  = '{2'd2, 1, B, 8'h33, 8'h33, 1};
      tbl[9]  = '{2'd2, 1, B, 8'h33, 8'h33, 1};
      tbl[10] = '{2'd2, 1, A, 8'h40, 8'h33, 1};
      tbl[11] = '{2'd2, 1, A, 8'h80, 8'h33, 1};
      tbl[12] = '{2'd2, 1, A, 8'h40, 8'h50, 0};
      tbl[13] = '{2'd1, 1, B, 8'h33, 8'h60, 0};
      tbl[14] = '{2'd1, 1, B, 8'h33, 8'h50, 0};
      tbl[15] = '{2'd1, 1, A, 8'h00, 8'h33, 1};
      tbl[16] = '{2'd1, 1, A, 8'hFF, 8'h33, 1};
      tbl[17] = '{2'd1, 1, B, 8'h33, 8'h00, 0};
      tbl[18] = '{2'd0, 1, B, 8'h33, 8'hBF, 0};
      tbl[19] = '{2'd0, 1, B, 8'h33, 8'h33, 1};
      tbl[20] = '{2'd0, 1, A, 8'h20, 8'h33, 1};
      tbl[21] = '{2'd0, 1, A, 8'h60, 8'h33, 1};
      tbl[22] = '{2'd2, 0, A, 8'hA0, 8'h20, 0};
      tbl[23] = '{2'd2, 0, A, 8'hE1, 8'h40, 0};
      tbl[24] = '{2'd2, 0, B, 8'h33, 8'h80, 0};
      tbl[25] = '{2'd2, 0, B, 8'h33, 8'hC1, 0};
      tbl[26] = '{2'd2, 0, A, 8'h11, 8'h33, 1};
      tbl[27] = '{2'd2, 0, A, 8'h22, 8'h33, 1};
      tbl[28] = '{2'd2, 0, A, 8'hFE, 8'h11, 0};
      tbl[29] = '{2'd2, 0, B, 8'h33, 8'h22, 0};
      tbl[30] = '{2'd2, 0, B, 8'h33, 8'hFE, 0};
      tbl[31] = '{2'd2, 0, B, 8'h33, 8'h33, 1};

      #2;
      do_reset("reset values");

      for (int i = 0; i < 32; i++) begin
         drive(1'b1, tbl[i].mode, tbl[i].en, tbl[i].blank, rep(tbl[i].r));
         check($sformatf("table[%0d]", i), rep(tbl[i].exp_r), tbl[i].exp_b);
      end

      // Reset asserted mid-line with pix_ce high, then a one-pixel line
      do_reset("reset before mid-line");
      for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 1'b1, B, rep(8'h33));
      drive(1'b1, 2'd0, 1'b1, A, rep(8'h44));
      drive(1'b1, 2'd0, 1'b1, A, rep(8'h55));
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset mid-line", '0, 1'b1);
      @(posedge clk);
      #1;
      check("reset held with ce", '0, 1'b1);
      @(negedge clk);
      pix_ce  = 1'b0;
      reset_n = 1'b1;
      drive(1'b1, 2'd2, 1'b1, B, rep(8'h33));
      drive(1'b1, 2'd2, 1'b1, B, rep(8'h33));
      drive(1'b1, 2'd2, 1'b1, A, 24'hC35A07);
      drive(1'b1, 2'd2, 1'b1, B, rep(8'h33));
      check("single px lead blank", rep(8'h33), 1'b1);
      drive(1'b1, 2'd2, 1'b1, B, rep(8'h33));
      check("single px line", 24'hC35A07, 1'b0);
      drive(1'b1, 2'd2, 1'b1, B, rep(8'h33));
      check("single px trail blank", rep(8'h33), 1'b1);

      // Random traffic, pix_ce roughly 1-in-4, checked every clock
      do_reset("reset before random");
      model_reset();
      rm  = 2'd0;
      ren = 1'b1;
      for (int i = 0; i < 800; i++) begin
         rce = ($urandom_range(0, 3) == 0);
         rb  = ($urandom_range(0, 4) == 0);
         rp  = PW'($urandom);
         if ($urandom_range(0, 19) == 0) rm  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) ren = 1'($urandom_range(0, 1));
         drive(rce, rm, ren, rb, rp);
         if (rce) model_step(rb, rp, rm, ren);
         check($sformatf("random[%0d] ce=%0b", i, rce), m_out, m_bout);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
